// File: rtl/axi_sram_slave_pkg.sv
// Shared types for the AXI SRAM responder: burst encodings, FSM state
// enums, the split read/write channel structs and a size-clamp helper.
package axi_sram_slave_pkg;

  localparam logic [1:0] AxiBurstFixed = 2'b00;
  localparam logic [1:0] AxiBurstIncr  = 2'b01;
  localparam logic [1:0] AxiBurstWrap  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } axi_rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } axi_wr_state_e;

  // Read request channel, master to subordinate (47 bits).
  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  // Read response channel, subordinate to master (35 bits).
  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;

  // Write request channel, master to subordinate (85 bits).
  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
  } axi_w_m2s_t;

  // Write response channel, subordinate to master (3 bits).
  typedef struct packed {
    logic awready;
    logic wready;
    logic bvalid;
  } axi_w_s2m_t;

  // The data bus is 32 bits, so transfer sizes above 4 bytes act as 4 bytes.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'd2) ? 3'd2 : size;
  endfunction

endpackage

// File: rtl/axi_sram_slave_burst_addr.sv
// Combinational next-beat address generator for one AXI burst:
// FIXED holds, INCR (and the reserved 2'b11) steps by the transfer size,
// WRAP steps within the (len+1)*size aligned window.
module axi_burst_addr
  import axi_sram_slave_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [7:0]  len_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_addr_o
);

  logic [2:0]  size_eff;
  logic [31:0] step;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;

  // Compute the stepped address and select according to burst type.
  always_comb begin
    size_eff  = clamp_size(size_i);
    step      = 32'd1 << size_eff;
    incr_addr = addr_i + step;
    wrap_mask = (({24'd0, len_i} + 32'd1) << size_eff) - 32'd1;
    case (burst_i)
      AxiBurstFixed: next_addr_o = addr_i;
      AxiBurstWrap:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:       next_addr_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 subordinate backing a word-organised SRAM. Independent read and
// write FSMs share one memory with a single read port and a single
// byte-enabled write port; a same-cycle read and write of one word
// returns the old data.
//
// Handshake: a transfer on any channel happens on a rising edge where
// both valid and ready are high; valid never waits on ready, and once
// rvalid/bvalid rise they and their payload hold until accepted.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter logic [31:0] AddrBase    = 32'h8000_0000,
  parameter int unsigned MemWords    = 4096,
  parameter int unsigned ReadLatency = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  axi_r_m2s_t r_req_i,
  output axi_r_s2m_t r_rsp_o,
  input  axi_w_m2s_t w_req_i,
  output axi_w_s2m_t w_rsp_o
);

  localparam int unsigned IdxW     = $clog2(MemWords);
  localparam logic [31:0] MemBytes = 32'(MemWords * 4);
  localparam logic [3:0]  LatLoad  = 4'(ReadLatency - 1);

  function automatic logic in_range(input logic [31:0] addr);
    return (addr - AddrBase) < MemBytes;
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
    return IdxW'((addr - AddrBase) >> 2);
  endfunction

  // ---------------- memory ----------------
  logic [31:0] mem_q [MemWords];
  logic [31:0] rd_word_q;

  // ---------------- read path state ----------------
  axi_rd_state_e rd_state_q, rd_state_d;
  logic [31:0]   rd_addr_q, rd_addr_d;
  logic [7:0]    rd_len_q, rd_len_d;
  logic [2:0]    rd_size_q, rd_size_d;
  logic [1:0]    rd_burst_q, rd_burst_d;
  logic [7:0]    rd_beat_q, rd_beat_d;
  logic [3:0]    rd_cnt_q, rd_cnt_d;
  logic          rd_hit_q, rd_hit_d;
  logic [31:0]   rd_next_addr;
  logic          rd_load;
  logic [31:0]   rd_load_addr;
  logic          arready, rvalid, rlast;

  // ---------------- write path state ----------------
  axi_wr_state_e wr_state_q, wr_state_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_len_q, wr_len_d;
  logic [2:0]    wr_size_q, wr_size_d;
  logic [1:0]    wr_burst_q, wr_burst_d;
  logic [31:0]   wr_next_addr;
  logic          mem_we;
  logic          awready, wready, bvalid;

  axi_burst_addr u_rd_burst (
    .addr_i      (rd_addr_q),
    .len_i       (rd_len_q),
    .size_i      (rd_size_q),
    .burst_i     (rd_burst_q),
    .next_addr_o (rd_next_addr)
  );

  axi_burst_addr u_wr_burst (
    .addr_i      (wr_addr_q),
    .len_i       (wr_len_q),
    .size_i      (wr_size_q),
    .burst_i     (wr_burst_q),
    .next_addr_o (wr_next_addr)
  );

  // Read FSM next state; rd_load fetches the word that rdata shows next.
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_addr_d    = rd_addr_q;
    rd_len_d     = rd_len_q;
    rd_size_d    = rd_size_q;
    rd_burst_d   = rd_burst_q;
    rd_beat_d    = rd_beat_q;
    rd_cnt_d     = rd_cnt_q;
    rd_load      = 1'b0;
    rd_load_addr = rd_addr_q;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rlast        = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (r_req_i.arvalid) begin
          rd_addr_d  = r_req_i.araddr;
          rd_len_d   = r_req_i.arlen;
          rd_size_d  = r_req_i.arsize;
          rd_burst_d = r_req_i.arburst;
          rd_beat_d  = 8'd0;
          rd_cnt_d   = LatLoad;
          if (ReadLatency == 1) begin
            rd_state_d   = R_DATA;
            rd_load      = 1'b1;
            rd_load_addr = r_req_i.araddr;
          end else begin
            rd_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        // The fetch happens in the last wait cycle so rvalid rises
        // exactly ReadLatency cycles after the AR handshake.
        if (rd_cnt_q <= 4'd1) begin
          rd_cnt_d   = 4'd0;
          rd_state_d = R_DATA;
          rd_load    = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (rd_beat_q == rd_len_q);
        if (r_req_i.rready) begin
          if (rlast) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_beat_d    = rd_beat_q + 8'd1;
            rd_addr_d    = rd_next_addr;
            rd_load      = 1'b1;
            rd_load_addr = rd_next_addr;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    rd_hit_d = rd_load ? in_range(rd_load_addr) : rd_hit_q;
  end

  // Read FSM registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_size_q  <= '0;
      rd_burst_q <= '0;
      rd_beat_q  <= '0;
      rd_cnt_q   <= '0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_size_q  <= rd_size_d;
      rd_burst_q <= rd_burst_d;
      rd_beat_q  <= rd_beat_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_hit_q   <= rd_hit_d;
    end
  end

  // Write FSM next state; the burst is closed by wlast, not by awlen.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_size_d  = wr_size_q;
    wr_burst_d = wr_burst_q;
    mem_we     = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        awready = 1'b1;
        if (w_req_i.awvalid) begin
          wr_addr_d  = w_req_i.awaddr;
          wr_len_d   = w_req_i.awlen;
          wr_size_d  = w_req_i.awsize;
          wr_burst_d = w_req_i.awburst;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (w_req_i.wvalid) begin
          mem_we    = in_range(wr_addr_q);
          wr_addr_d = wr_next_addr;
          if (w_req_i.wlast) begin
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (w_req_i.bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_size_q  <= wr_size_d;
      wr_burst_q <= wr_burst_d;
    end
  end

  // SRAM: byte-enabled write and registered read; contents survive reset,
  // but accesses in a reset cycle are suppressed so abandoned beats leave no trace.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && !reset && w_req_i.wstrb[b]) begin
        mem_q[word_idx(wr_addr_q)][8*b +: 8] <= w_req_i.wdata[8*b +: 8];
      end
    end
    if (rd_load && !reset) begin
      rd_word_q <= mem_q[word_idx(rd_load_addr)];
    end
  end

  // Drive the response structs; everything is forced low while reset is high.
  always_comb begin
    r_rsp_o = '0;
    w_rsp_o = '0;
    if (!reset) begin
      r_rsp_o.arready = arready;
      r_rsp_o.rvalid  = rvalid;
      r_rsp_o.rdata   = rd_hit_q ? rd_word_q : 32'h0;
      r_rsp_o.rlast   = rlast;
      w_rsp_o.awready = awready;
      w_rsp_o.wready  = wready;
      w_rsp_o.bvalid  = bvalid;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: memory is preloaded through the
// write channel, then reads, strobes, range checks, concurrency and
// reset are exercised against hand-computed expected words.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  localparam int Timeout = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  axi_r_m2s_t r_req;
  axi_r_s2m_t r_rsp;
  axi_w_m2s_t w_req;
  axi_w_s2m_t w_rsp;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  axi_sram_slave #(
    .AddrBase   (32'h8000_0000),
    .MemWords   (4096),
    .ReadLatency(1)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .r_req_i(r_req),
    .r_rsp_o(r_rsp),
    .w_req_i(w_req),
    .w_rsp_o(w_rsp)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    w_req.awvalid = 1'b1;
    w_req.awaddr  = addr;
    w_req.awlen   = len;
    w_req.awsize  = size;
    w_req.awburst = burst;
    while (w_rsp.awready !== 1'b1 && t < Timeout) begin
      tick();
      t++;
    end
    if (t == Timeout) begin
      n_cmp++; n_err++;
      $display("FAIL awready_wait: got %b expected 1", w_rsp.awready);
    end
    tick();
    w_req.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int t = 0;
    w_req.wvalid = 1'b1;
    w_req.wdata  = data;
    w_req.wstrb  = strb;
    w_req.wlast  = last;
    while (w_rsp.wready !== 1'b1 && t < Timeout) begin
      tick();
      t++;
    end
    if (t == Timeout) begin
      n_cmp++; n_err++;
      $display("FAIL wready_wait: got %b expected 1", w_rsp.wready);
    end
    tick();
    w_req.wvalid = 1'b0;
    w_req.wlast  = 1'b0;
  endtask

  // Called the cycle after the wlast handshake: bvalid must already be up.
  task automatic b_take(input string name);
    int t = 0;
    n_cmp++;
    if (w_rsp.bvalid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_bvalid: got %b expected 1", name, w_rsp.bvalid);
    end
    while (w_rsp.bvalid !== 1'b1 && t < Timeout) begin
      tick();
      t++;
    end
    w_req.bready = 1'b1;
    tick();
    w_req.bready = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input string name);
    aw_send(addr, 8'd0, 3'd2, AxiBurstIncr);
    w_beat(data, strb, 1'b1);
    b_take(name);
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    r_req.arvalid = 1'b1;
    r_req.araddr  = addr;
    r_req.arlen   = len;
    r_req.arsize  = size;
    r_req.arburst = burst;
    while (r_rsp.arready !== 1'b1 && t < Timeout) begin
      tick();
      t++;
    end
    if (t == Timeout) begin
      n_cmp++; n_err++;
      $display("FAIL arready_wait: got %b expected 1", r_rsp.arready);
    end
    tick();
    r_req.arvalid = 1'b0;
  endtask

  // Reads len+1 beats with rready held high, checking each against exp_q.
  // With strict set, every beat must be valid without a bubble.
  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input bit strict, input string name);
    logic [31:0] exp_w;
    ar_send(addr, len, size, burst);
    r_req.rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      int t = 0;
      if (strict) begin
        n_cmp++;
        if (r_rsp.rvalid !== 1'b1) begin
          n_err++;
          $display("FAIL %s_nobubble[%0d]: got rvalid=%b expected 1", name, i, r_rsp.rvalid);
        end
      end
      while (r_rsp.rvalid !== 1'b1 && t < Timeout) begin
        tick();
        t++;
      end
      exp_w = exp_q.pop_front();
      n_cmp++;
      if (r_rsp.rdata !== exp_w) begin
        n_err++;
        $display("FAIL %s_rdata[%0d]: got %h expected %h", name, i, r_rsp.rdata, exp_w);
      end
      n_cmp++;
      if (r_rsp.rlast !== (i == int'(len))) begin
        n_err++;
        $display("FAIL %s_rlast[%0d]: got %b expected %b", name, i, r_rsp.rlast, (i == int'(len)));
      end
      tick();
    end
    r_req.rready = 1'b0;
  endtask

  task automatic read_one(input logic [31:0] addr, input logic [31:0] exp_w, input string name);
    exp_q.push_back(exp_w);
    read_burst(addr, 8'd0, 3'd2, AxiBurstIncr, 1'b1, name);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    n_cmp++;
    if (r_rsp !== '0) begin n_err++; $display("FAIL reset_r_rsp: got %h expected 0", r_rsp); end
    n_cmp++;
    if (w_rsp !== '0) begin n_err++; $display("FAIL reset_w_rsp: got %h expected 0", w_rsp); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (r_rsp.arready !== 1'b1 || w_rsp.awready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got ar=%b aw=%b expected 1 1", r_rsp.arready, w_rsp.awready);
    end
  endtask

  // word0 = DEADBEEF, words 4..15 = C0DE_0000+idx, word16 = AAAAAAAA,
  // word17 = 5555_0001, word19 = 5A5A_0013
  task automatic test_preload();
    write_word(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, "pre_w0");
    aw_send(32'h8000_0010, 8'd11, 3'd2, AxiBurstIncr);
    for (int i = 0; i < 12; i++) w_beat(32'hC0DE_0004 + 32'(i), 4'hF, i == 11);
    b_take("pre_burst");
    write_word(32'h8000_0040, 32'hAAAA_AAAA, 4'hF, "pre_w16");
    write_word(32'h8000_0044, 32'h5555_0001, 4'hF, "pre_w17");
    write_word(32'h8000_004C, 32'h5A5A_0013, 4'hF, "pre_w19");
  endtask

  task automatic test_single_read();
    ar_send(32'h8000_0000, 8'd0, 3'd2, AxiBurstIncr);
    n_cmp++;
    if (r_rsp.rvalid !== 1'b1 || r_rsp.rdata !== 32'hDEAD_BEEF || r_rsp.rlast !== 1'b1) begin
      n_err++;
      $display("FAIL single_read: got v=%b d=%h l=%b expected 1 deadbeef 1",
               r_rsp.rvalid, r_rsp.rdata, r_rsp.rlast);
    end
    r_req.rready = 1'b1;
    tick();
    r_req.rready = 1'b0;
    n_cmp++;
    if (r_rsp.arready !== 1'b1 || r_rsp.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_read_idle: got ar=%b v=%b expected 1 0", r_rsp.arready, r_rsp.rvalid);
    end
  endtask

  task automatic test_line_fill();
    int beat = 0;
    int cyc = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hC0DE_0008 + 32'(i));
    read_burst(32'h8000_0020, 8'd7, 3'd2, AxiBurstIncr, 1'b1, "fill");
    n_cmp++;
    if (r_rsp.rvalid !== 1'b0) begin n_err++; $display("FAIL fill_done: got rvalid=%b expected 0", r_rsp.rvalid); end
    // Same line with rready toggling: data must hold while stalled.
    ar_send(32'h8000_0020, 8'd7, 3'd2, AxiBurstIncr);
    while (beat < 8 && cyc < 40) begin
      r_req.rready = (cyc % 2 == 0);
      n_cmp++;
      if (r_rsp.rvalid !== 1'b1 || r_rsp.rdata !== 32'hC0DE_0008 + 32'(beat) ||
          r_rsp.rlast !== (beat == 7)) begin
        n_err++;
        $display("FAIL fill_stall[%0d]: got v=%b d=%h l=%b expected 1 %h %b", cyc,
                 r_rsp.rvalid, r_rsp.rdata, r_rsp.rlast, 32'hC0DE_0008 + 32'(beat), (beat == 7));
      end
      if (r_req.rready) beat++;
      tick();
      cyc++;
    end
    r_req.rready = 1'b0;
  endtask

  task automatic test_burst_modes();
    exp_q.push_back(32'hC0DE_0006); exp_q.push_back(32'hC0DE_0007);
    exp_q.push_back(32'hC0DE_0004); exp_q.push_back(32'hC0DE_0005);
    read_burst(32'h8000_0018, 8'd3, 3'd2, AxiBurstWrap, 1'b1, "wrap");
    for (int i = 0; i < 3; i++) exp_q.push_back(32'hC0DE_0009);
    read_burst(32'h8000_0024, 8'd2, 3'd2, AxiBurstFixed, 1'b1, "fixed");
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0DE_000C);
    read_burst(32'h8000_0030, 8'd3, 3'd0, AxiBurstIncr, 1'b1, "narrow");
    exp_q.push_back(32'hC0DE_000E); exp_q.push_back(32'hC0DE_000F);
    read_burst(32'h8000_0038, 8'd1, 3'd3, AxiBurstIncr, 1'b1, "size3");
    exp_q.push_back(32'hC0DE_000A); exp_q.push_back(32'hC0DE_000B);
    read_burst(32'h8000_0028, 8'd1, 3'd2, 2'b11, 1'b1, "burst3");
  endtask

  task automatic test_strobe();
    aw_send(32'h8000_0040, 8'd0, 3'd2, AxiBurstIncr);
    w_beat(32'h1122_3344, 4'b0101, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (w_rsp.bvalid !== 1'b1) begin n_err++; $display("FAIL strobe_bhold[%0d]: got %b expected 1", i, w_rsp.bvalid); end
      tick();
    end
    w_req.bready = 1'b1;
    tick();
    w_req.bready = 1'b0;
    n_cmp++;
    if (w_rsp.bvalid !== 1'b0 || w_rsp.awready !== 1'b1) begin
      n_err++;
      $display("FAIL strobe_bdone: got b=%b aw=%b expected 0 1", w_rsp.bvalid, w_rsp.awready);
    end
    read_one(32'h8000_0040, 32'hAA22_AA44, "strobe_rb");
    // Early wlast on a len=3 burst: only the first word is written.
    aw_send(32'h8000_0048, 8'd3, 3'd2, AxiBurstIncr);
    w_beat(32'h1234_5678, 4'hF, 1'b1);
    b_take("early");
    read_one(32'h8000_0048, 32'h1234_5678, "early_w18");
    read_one(32'h8000_004C, 32'h5A5A_0013, "early_w19");
  endtask

  task automatic test_out_of_range();
    write_word(32'h8001_0000, 32'hFFFF_FFFF, 4'hF, "oor_write");
    read_one(32'h8001_0000, 32'h0000_0000, "oor_read");
    read_one(32'h8000_0000, 32'hDEAD_BEEF, "oor_alias");
  endtask

  task automatic test_concurrent();
    aw_send(32'h8000_0044, 8'd0, 3'd2, AxiBurstIncr);
    r_req.arvalid = 1'b1; r_req.araddr = 32'h8000_0044; r_req.arlen = 8'd0;
    r_req.arsize = 3'd2; r_req.arburst = AxiBurstIncr;
    w_req.wvalid = 1'b1; w_req.wdata = 32'h7777_0002; w_req.wstrb = 4'hF; w_req.wlast = 1'b1;
    n_cmp++;
    if (r_rsp.arready !== 1'b1 || w_rsp.wready !== 1'b1) begin
      n_err++;
      $display("FAIL conc_ready: got ar=%b w=%b expected 1 1", r_rsp.arready, w_rsp.wready);
    end
    tick();
    r_req.arvalid = 1'b0; w_req.wvalid = 1'b0; w_req.wlast = 1'b0;
    n_cmp++;
    if (r_rsp.rvalid !== 1'b1 || r_rsp.rdata !== 32'h5555_0001 || w_rsp.bvalid !== 1'b1) begin
      n_err++;
      $display("FAIL conc_readfirst: got v=%b d=%h b=%b expected 1 55550001 1",
               r_rsp.rvalid, r_rsp.rdata, w_rsp.bvalid);
    end
    r_req.rready = 1'b1; w_req.bready = 1'b1;
    tick();
    r_req.rready = 1'b0; w_req.bready = 1'b0;
    read_one(32'h8000_0044, 32'h7777_0002, "conc_new");
    // AR and AW accepted on the same edge.
    r_req.arvalid = 1'b1; r_req.araddr = 32'h8000_0010;
    w_req.awvalid = 1'b1; w_req.awaddr = 32'h8000_0054; w_req.awlen = 8'd0;
    w_req.awsize = 3'd2; w_req.awburst = AxiBurstIncr;
    tick();
    r_req.arvalid = 1'b0; w_req.awvalid = 1'b0;
    n_cmp++;
    if (r_rsp.rvalid !== 1'b1 || r_rsp.rdata !== 32'hC0DE_0004 || w_rsp.wready !== 1'b1) begin
      n_err++;
      $display("FAIL conc_arw: got v=%b d=%h w=%b expected 1 c0de0004 1",
               r_rsp.rvalid, r_rsp.rdata, w_rsp.wready);
    end
    r_req.rready = 1'b1;
    tick();
    r_req.rready = 1'b0;
    w_beat(32'h0BAD_0015, 4'hF, 1'b1);
    b_take("conc_arw");
  endtask

  task automatic test_reset_mid();
    ar_send(32'h8000_0020, 8'd7, 3'd2, AxiBurstIncr);
    r_req.rready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (r_rsp.rdata !== 32'hC0DE_000B || r_rsp.rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_beat3: got v=%b d=%h expected 1 c0de000b", r_rsp.rvalid, r_rsp.rdata);
    end
    aw_send(32'h8000_0050, 8'd3, 3'd2, AxiBurstIncr);
    w_beat(32'hBEEF_0014, 4'hF, 1'b0);
    w_req.wvalid = 1'b1; w_req.wdata = 32'hDEAD_0015; w_req.wstrb = 4'hF;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (r_rsp !== '0 || w_rsp !== '0) begin
        n_err++;
        $display("FAIL rstmid_zero[%0d]: got r=%h w=%h expected 0 0", i, r_rsp, w_rsp);
      end
      tick();
    end
    reset = 1'b0; r_req.rready = 1'b0; w_req.wvalid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (r_rsp.arready !== 1'b1 || w_rsp.awready !== 1'b1 ||
          r_rsp.rvalid !== 1'b0 || w_rsp.bvalid !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_idle[%0d]: got ar=%b aw=%b v=%b b=%b expected 1 1 0 0", i,
                 r_rsp.arready, w_rsp.awready, r_rsp.rvalid, w_rsp.bvalid);
      end
      tick();
    end
    read_one(32'h8000_0020, 32'hC0DE_0008, "rstmid_keep8");
    read_one(32'h8000_0040, 32'hAA22_AA44, "rstmid_keep16");
    read_one(32'h8000_0050, 32'hBEEF_0014, "rstmid_keep20");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    r_req = '0;
    w_req = '0;
    test_reset();
    test_preload();
    test_single_read();
    test_line_fill();
    test_burst_modes();
    test_strobe();
    test_out_of_range();
    test_concurrent();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
